uart_tx_arbiter: RTL and testbench

Shares one byte-wide UART transmitter among `N_REQ` requesters on a packet basis. Each requester presents bytes with a valid/ready handshake and marks its final byte with `last`. The arbiter grants round-robin at packet boundaries and feeds the transmitter through its write/busy interface, holding each byte until the transmitter has accepted it. It sits between the on-chip message sources (status reporters, debug dumpers) and the single `uart_tx` instance driving the board's TX pin.

---
 rtl/uart_tx_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one byte-wide UART transmitter among N_REQ requesters, packet by
//   packet. Grants are round-robin and only change at packet boundaries; each
//   byte is held on o_tx_data with o_tx_write high until the transmitter
//   shows busy, then the arbiter waits for busy to fall before the next byte.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  WRITE cycles allowed without i_tx_busy (watchdog build only)
//
// Ports
//   i_clk, i_reset             clock, async active-high reset
//   i_req_valid/_data/_last    per-requester byte stream (byte k at [8k+7:8k])
//   o_req_ready                one-hot, only in LOAD, equals the grant
//   o_grant                    one-hot owner, zero when unowned
//   o_tx_write, o_tx_data      write request / held byte to the transmitter
//   i_tx_busy                  transmitter busy (acceptance through stop bit)
//   o_timeout                  one-cycle watchdog pulse
//
// Build option
//   UART_ARB_TIMEOUT_EN  enables the write watchdog; without it WRITE waits
//                        forever and o_timeout is tied low.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_tx_write,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_busy,
  output logic               o_timeout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic [IW-1:0]      last_grant, last_grant_nxt;
  logic               last_q;
  logic               load_en;

  logic [N_REQ-1:0][7:0] req_data;
  assign req_data = i_req_data;

  // ---------------------------------------------------------------------------
  // Granted requester's byte (grant is one-hot, so OR-ing is a clean mux)
  // ---------------------------------------------------------------------------
  logic       gnt_valid, gnt_last;
  logic [7:0] gnt_data;

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (o_grant[k]) begin
        gnt_data = gnt_data | req_data[k];
        gnt_last = gnt_last | i_req_last[k];
      end
    end
  end

  assign gnt_valid = |(i_req_valid & o_grant);

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid requester after last_grant, wrapping
  // ---------------------------------------------------------------------------
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  int            idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant;
    cand      = '0;
    idx       = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IW'(idx);
      if (!win_found && i_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write watchdog
  // ---------------------------------------------------------------------------
  logic tmo_fire;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Fires in the TIMEOUT-th consecutive WRITE cycle that still has no busy.
  assign tmo_fire = (state == WRITE) && !i_tx_busy && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                           tmo_cnt <= '0;
    else if (state == WRITE && !i_tx_busy) tmo_cnt <= tmo_cnt + TW'(1);
    else                                   tmo_cnt <= '0;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  assign o_timeout = tmo_fire;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    grant_nxt      = o_grant;
    last_grant_nxt = last_grant;
    load_en        = 1'b0;
    case (state)
      IDLE: begin
        if (!i_tx_busy && win_found) begin
          grant_nxt      = N_REQ'(1) << win_idx;
          last_grant_nxt = win_idx;
          state_nxt      = LOAD;
        end
      end
      LOAD: begin
        // A stalled owner keeps the grant; there is no preemption.
        if (gnt_valid) begin
          load_en   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        // Hold write until busy is seen: the transmitter may only sample it
        // on a baud tick.
        if (i_tx_busy) begin
          state_nxt = DRAIN;
        end else if (tmo_fire) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (!i_tx_busy) begin
          if (last_q) begin
            grant_nxt = '0;
            state_nxt = IDLE;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      o_grant    <= '0;
      last_grant <= IW'(N_REQ - 1);
      o_tx_data  <= '0;
      last_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_grant    <= grant_nxt;
      last_grant <= last_grant_nxt;
      if (load_en) begin
        o_tx_data <= gnt_data;
        last_q    <= gnt_last;
      end
    end
  end

  // Decoded from state so both drop the instant reset is applied.
  assign o_req_ready = (state == LOAD) ? o_grant : '0;
  assign o_tx_write  = (state == WRITE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int TMO = 16;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [NR-1:0]     i_req_valid = '0;
  logic [8*NR-1:0]   i_req_data = '0;
  logic [NR-1:0]     i_req_last = '0;
  logic [NR-1:0]     o_req_ready;
  logic [NR-1:0]     o_grant;
  logic              o_tx_write;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy = 1'b0;
  logic              o_timeout;

  always #5 i_clk = ~i_clk;

  uart_tx_arbiter #(.N_REQ(NR), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready), .o_grant(o_grant),
    .o_tx_write(o_tx_write), .o_tx_data(o_tx_data),
    .i_tx_busy(i_tx_busy), .o_timeout(o_timeout)
  );

  int checks = 0;
  int failures = 0;

  // Stimulus queues ({last, byte}) and the scoreboard's expected bytes.
  logic [8:0] drv_q [NR][$];
  logic [8:0] exp_q [NR][$];
  int         stall [NR];
  int         stall_once [NR];
  bit         rand_stall = 0;
  logic [NR-1:0] fire_v = '0;

  int tx_mode = 0;   // 0 model transmitter, 1 busy forced high, 2 busy never rises
  int tx_dly = 5, tx_hold = 20;
  bit tx_rand = 0;

  int tmo_count = 0;
  int grant_log [$];

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  function automatic string log_str();
    string s = "";
    foreach (grant_log[i]) s = {s, $sformatf("%0d", grant_log[i])};
    return s;
  endfunction

  function automatic int gidx(input logic [NR-1:0] g);
    for (int k = 0; k < NR; k++) if (g[k]) return k;
    return -1;
  endfunction

  // Round-robin rule: first pending requester after the previous winner.
  function automatic int rr_pick(input int rr, input logic [NR-1:0] v);
    for (int off = 1; off <= NR; off++) if (v[(rr + off) % NR]) return (rr + off) % NR;
    return -1;
  endfunction

  task automatic push_byte(input int k, input logic [7:0] d, input bit last);
    drv_q[k].push_back({last, d});
    exp_q[k].push_back({last, d});
  endtask

  task automatic push_pkt(input int k, input int len);
    for (int i = 0; i < len; i++) push_byte(k, 8'($urandom), i == len - 1);
  endtask

  task automatic flush();
    for (int k = 0; k < NR; k++) begin
      drv_q[k].delete(); exp_q[k].delete(); stall[k] = 0; stall_once[k] = 0;
    end
    grant_log.delete();
  endtask

  task automatic assert_reset();
    i_reset = 1'b1;
    flush();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge i_clk);
    #2 i_reset = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, o_req_ready == '0, o_req_ready, 0);
    chk({tag, "_grant"}, o_grant == '0, o_grant, 0);
    chk({tag, "_write"}, o_tx_write == 1'b0, o_tx_write, 0);
    chk({tag, "_data"},  o_tx_data == 8'h00, o_tx_data, 0);
    chk({tag, "_timeout"}, o_timeout == 1'b0, o_timeout, 0);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    bit busy_q;
    busy_q = 1'b1;
    while (busy_q && n < max) begin
      @(negedge i_clk);
      n++;
      busy_q = (o_grant != '0) || o_tx_write;
      for (int k = 0; k < NR; k++) if (drv_q[k].size() != 0 || exp_q[k].size() != 0) busy_q = 1'b1;
    end
    chk({tag, "_drain_in_budget"}, !busy_q, n, max);
  endtask

  // Requester drivers: present queue heads, pop on a sampled handshake.
  initial begin
    logic [8:0] b;
    forever begin
      @(negedge i_clk);
      fire_v = i_reset ? '0 : (i_req_valid & o_req_ready);
      @(posedge i_clk);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (fire_v[k] && drv_q[k].size() > 0) begin
          b = drv_q[k].pop_front();
          if (!b[8]) begin
            if (stall_once[k] > 0) begin
              stall[k] = stall_once[k];
              stall_once[k] = 0;
            end else if (rand_stall && $urandom_range(0, 2) == 0) begin
              stall[k] = $urandom_range(1, 8);
            end
          end
        end
        if (stall[k] > 0) begin
          stall[k]--;
          i_req_valid[k] = 1'b0;
        end else if (drv_q[k].size() > 0) begin
          b = drv_q[k][0];
          i_req_valid[k] = 1'b1;
          i_req_data[8*k +: 8] = b[7:0];
          i_req_last[k] = b[8];
        end else begin
          i_req_valid[k] = 1'b0;
          i_req_last[k] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: busy rises dly cycles after write, stays up hold cycles.
  initial begin
    int d, h, hold;
    d = 0; h = 0; hold = 0;
    forever begin
      @(posedge i_clk);
      #1;
      if (i_reset) begin
        i_tx_busy = 1'b0; d = 0; h = 0;
      end else if (tx_mode == 1) begin
        i_tx_busy = 1'b1;
      end else if (tx_mode == 2) begin
        i_tx_busy = 1'b0; d = 0; h = 0;
      end else if (h > 0) begin
        h--;
        i_tx_busy = (h > 0);
      end else if (d > 0) begin
        d--;
        if (d == 0) begin i_tx_busy = 1'b1; h = hold; end
      end else begin
        i_tx_busy = 1'b0;
        if (o_tx_write) begin
          d    = tx_rand ? $urandom_range(1, 6) : tx_dly;
          hold = tx_rand ? $urandom_range(1, 20) : tx_hold;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [NR-1:0] pg, pv;
    logic [7:0] pd;
    logic [8:0] e;
    bit pb, pw, ptmo, prev_ok, in_pkt, need_rel;
    int rr, wr_run, g, w;
    pg = '0; pv = '0; pd = '0; pb = 0; pw = 0; ptmo = 0;
    prev_ok = 0; in_pkt = 0; need_rel = 0; rr = NR - 1; wr_run = 0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        prev_ok = 0; in_pkt = 0; need_rel = 0; rr = NR - 1; wr_run = 0;
        continue;
      end
      chk("ready_onehot_owned", ((o_req_ready & ~o_grant) == '0) && ($countones(o_req_ready) <= 1),
          o_req_ready, o_grant);
      chk("grant_onehot", $countones(o_grant) <= 1, o_grant, 0);
`ifndef UART_ARB_TIMEOUT_EN
      chk("timeout_tied_low", o_timeout == 1'b0, o_timeout, 0);
`endif
      if (prev_ok) begin
        if (pg == '0 && pv != '0 && !pb) begin
          w = rr_pick(rr, pv);
          chk("arb_winner", o_grant == (NR'(1) << w), o_grant, NR'(1) << w);
          rr = w;
          if (o_grant != '0) grant_log.push_back(gidx(o_grant));
        end else if (pg == '0 && o_grant != '0) begin
          chk("arb_spurious_grant", 1'b0, o_grant, 0);
        end
        if (pg != '0 && o_grant != '0 && o_grant != pg) chk("grant_switch_mid_pkt", 1'b0, o_grant, pg);
        if (pg != '0 && o_grant == '0) begin
          chk("release_mid_pkt", !in_pkt || ptmo, in_pkt, 0);
          in_pkt = 0; need_rel = 0;
        end
        if (pw && !o_tx_write) chk("write_held_until_busy", pb || ptmo, pb, 1);
        if (pw && o_tx_write)  chk("tx_data_stable", o_tx_data == pd, o_tx_data, pd);
      end
      wr_run = o_tx_write ? wr_run + 1 : 0;
      if (o_tx_write && (i_tx_busy || o_timeout)) begin
        g = gidx(o_grant);
        chk("grant_during_write", g >= 0, o_grant, 1);
        if (g >= 0) begin
          if (exp_q[g].size() == 0) begin
            chk("unexpected_byte", 1'b0, o_tx_data, g);
          end else begin
            e = exp_q[g].pop_front();
            chk("tx_data", o_tx_data == e[7:0], o_tx_data, e[7:0]);
            chk("released_after_last", !need_rel, need_rel, 0);
            need_rel = e[8];
            in_pkt = !e[8];
          end
        end
        if (o_timeout) begin
          tmo_count++;
          chk("timeout_cycle", wr_run == TMO, wr_run, TMO);
          in_pkt = 0;
          need_rel = 1;
        end
      end
      pg = o_grant; pv = i_req_valid; pb = i_tx_busy; pw = o_tx_write;
      pd = o_tx_data; ptmo = o_timeout; prev_ok = 1;
    end
  end

  // Hard stop in case something wedges outside a bounded wait.
  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int npk;
    for (int k = 0; k < NR; k++) begin stall[k] = 0; stall_once[k] = 0; end

    // Reset state
    repeat (2) @(negedge i_clk);
    chk_outputs_zero("reset");
    release_reset();

    // Single requester sends "Hi"
    push_byte(0, 8'h48, 1'b0);
    push_byte(0, 8'h69, 1'b1);
    wait_idle("hi", 400);
    chk_str("hi_grant_order", log_str(), "0");
    chk("hi_grant_released", o_grant == '0, o_grant, 0);

    // Round-robin among three always-valid requesters
    assert_reset();
    for (int r = 0; r < 3; r++) for (int k = 0; k < 3; k++) push_pkt(k, 2);
    release_reset();
    wait_idle("rr", 3000);
    chk_str("rr_grant_order", log_str(), "012012012");

    // Owner stalls mid-packet while another requester waits
    assert_reset();
    release_reset();
    stall_once[1] = 50;
    push_byte(1, 8'hA1, 1'b0);
    push_byte(1, 8'hA2, 1'b1);
    repeat (3) @(negedge i_clk);
    push_pkt(2, 2);
    begin
      int n = 0;
      while (!(o_req_ready[1] && i_req_valid[1]) && n < 50) begin @(negedge i_clk); n++; end
      chk("stall_first_byte_seen", n < 50, n, 50);
    end
    repeat (40) @(negedge i_clk);
    chk("stall_grant_held", o_grant == 4'b0010, o_grant, 4'b0010);
    chk("stall_ready_owner_only", o_req_ready == 4'b0010, o_req_ready, 4'b0010);
    wait_idle("stall", 1000);
    chk_str("stall_grant_order", log_str(), "12");

    // Busy already high when a request appears
    grant_log.delete();
    tx_mode = 1;
    repeat (2) @(negedge i_clk);
    push_byte(3, 8'h5A, 1'b1);
    repeat (10) @(negedge i_clk);
    chk("busy_no_grant", o_grant == '0, o_grant, 0);
    chk("busy_no_ready", o_req_ready == '0, o_req_ready, 0);
    tx_mode = 0;
    wait_idle("busy", 400);
    chk_str("busy_grant_order", log_str(), "3");

    // Reset while a write is outstanding
    push_pkt(2, 3);
    begin
      int n = 0;
      while (!o_tx_write && n < 100) begin @(negedge i_clk); n++; end
      chk("rst_write_seen", o_tx_write == 1'b1, o_tx_write, 1);
    end
    #2 i_reset = 1'b1;
    #1 chk_outputs_zero("rst_async");
    flush();
    release_reset();
    push_byte(3, 8'hC3, 1'b1);
    push_byte(0, 8'hC0, 1'b1);
    wait_idle("rst", 400);
    chk_str("rst_priority_order", log_str(), "03");

    // Randomized traffic
    grant_log.delete();
    tx_rand = 1;
    rand_stall = 1;
    npk = 0;
    for (int i = 0; i < 40; i++) begin
      push_pkt($urandom_range(0, NR - 1), $urandom_range(1, 4));
      npk++;
      repeat ($urandom_range(0, 30)) @(negedge i_clk);
    end
    wait_idle("rand", 30000);
    chk("rand_packet_count", grant_log.size() == npk, grant_log.size(), npk);
    tx_rand = 0;
    rand_stall = 0;

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never responds
    assert_reset();
    release_reset();
    tx_mode = 2;
    tmo_count = 0;
    push_byte(0, 8'h11, 1'b1);
    push_byte(1, 8'h22, 1'b1);
    wait_idle("tmo", 400);
    chk("tmo_pulses", tmo_count == 2, tmo_count, 2);
    chk_str("tmo_grant_order", log_str(), "01");
    tx_mode = 0;
`endif

    repeat (5) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
